// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM controller: nametable/palette RAM, CHR address decode, renderer read
// port and the CPU PPUADDR/PPUDATA/PPUSTATUS access path with read buffer.
module ppu_vram_ctrl #(
  parameter int unsigned NT_BYTES  = 2048,
  parameter int unsigned PAL_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] render_addr,
  input  logic        render_active,
  output logic [7:0]  render_data,
  input  logic [2:0]  cpu_reg_sel,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_busy,
  input  logic        inc32,
  input  logic        mirror_vertical,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_data
);
  localparam int unsigned NT_AW  = $clog2(NT_BYTES);
  localparam int unsigned PAL_AW = $clog2(PAL_BYTES);
  localparam logic [2:0]  SEL_STATUS = 3'd2;
  localparam logic [2:0]  SEL_ADDR   = 3'd6;
  localparam logic [2:0]  SEL_DATA   = 3'd7;

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_CAPT} state_e;

  function automatic logic [NT_AW-1:0] nt_idx(input logic [11:0] a, input logic mv);
    logic [10:0] idx;
    idx = {mv ? a[10] : a[11], a[9:0]};
    return NT_AW'(idx);
  endfunction

  // Sprite-zero-style mirrors: 0x10/0x14/0x18/0x1C fold onto 0x00/0x04/0x08/0x0C
  function automatic logic [PAL_AW-1:0] pal_idx(input logic [4:0] a);
    logic [4:0] idx;
    idx = {a[4] & (a[1:0] != 2'b00), a[3:0]};
    return PAL_AW'(idx);
  endfunction

  logic [7:0] nt_mem  [NT_BYTES];
  logic [7:0] pal_mem [PAL_BYTES];

  state_e      state_q, state_d;
  logic [14:0] v_q, v_d;
  logic        w_q, w_d;
  logic [7:0]  buf_q, buf_d;
  logic [7:0]  render_data_q, render_data_d;
  logic [7:0]  cpu_data_out_q, cpu_data_out_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic [13:0] addr_q, addr_d;
  logic        own_q, own_d;

  logic [13:0] va, v_inc, v_alias;
  logic [7:0]  rd_data;
  logic        nt_we, pal_we;
  logic [NT_AW-1:0]  nt_wa;
  logic [PAL_AW-1:0] pal_wa;
  logic        unused_bits;

  assign va          = v_q[13:0];
  assign v_inc       = va + (inc32 ? 14'd32 : 14'd1);
  assign v_alias     = va - 14'h1000;
  assign unused_bits = ^{render_addr[15:14], v_q[14]};

  // Shared read port: decodes whichever address stage 1 captured
  always_comb begin
    rd_data = nt_mem[nt_idx(addr_q[11:0], mirror_vertical)];
    if (!addr_q[13]) begin
      rd_data = chr_data;
    end else if (addr_q[13:8] == 6'h3F) begin
      rd_data = pal_mem[pal_idx(addr_q[4:0])];
    end
  end

  always_comb begin
    state_d        = state_q;
    v_d            = v_q;
    w_d            = w_q;
    buf_d          = buf_q;
    cpu_data_out_d = cpu_data_out_q;
    wdata_d        = wdata_q;
    nt_we          = 1'b0;
    pal_we         = 1'b0;
    nt_wa          = nt_idx(va[11:0], mirror_vertical);
    pal_wa         = pal_idx(va[4:0]);
    render_data_d  = rd_data;
    // CPU borrows the read port only while the renderer is idle
    own_d          = (state_q == RD_ISSUE) && !render_active;
    addr_d         = own_d ? va : render_addr[13:0];

    unique case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          if (cpu_reg_sel == SEL_ADDR) begin
            if (!w_q) v_d = {1'b0, cpu_data_in[5:0], v_q[7:0]};
            else      v_d = {v_q[14:8], cpu_data_in};
            w_d = !w_q;
          end else if (cpu_reg_sel == SEL_DATA) begin
            wdata_d = cpu_data_in;
            state_d = WR;
          end
        end else if (cpu_rd) begin
          if (cpu_reg_sel == SEL_STATUS) begin
            w_d = 1'b0;
          end else if (cpu_reg_sel == SEL_DATA) begin
            cpu_data_out_d = buf_q;
            state_d        = RD_ISSUE;
          end
        end
      end
      WR: begin
        if (!render_active && va[13]) begin
          if (va[13:8] == 6'h3F) pal_we = 1'b1;
          else                   nt_we  = 1'b1;
        end
        v_d     = {1'b0, v_inc};
        state_d = IDLE;
      end
      RD_ISSUE: begin
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        if (own_q && !render_active) begin
          if (va[13:8] == 6'h3F) begin
            cpu_data_out_d = pal_mem[pal_idx(va[4:0])];
            buf_d          = nt_mem[nt_idx(v_alias[11:0], mirror_vertical)];
          end else begin
            buf_d = rd_data;
          end
        end
        v_d     = {1'b0, v_inc};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (nt_we)  nt_mem[nt_wa]   <= wdata_q;
    if (pal_we) pal_mem[pal_wa] <= wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      v_q            <= '0;
      w_q            <= 1'b0;
      buf_q          <= '0;
      render_data_q  <= '0;
      cpu_data_out_q <= '0;
      wdata_q        <= '0;
      busy_q         <= 1'b0;
      addr_q         <= '0;
      own_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      v_q            <= v_d;
      w_q            <= w_d;
      buf_q          <= buf_d;
      render_data_q  <= render_data_d;
      cpu_data_out_q <= cpu_data_out_d;
      wdata_q        <= wdata_d;
      busy_q         <= busy_d;
      addr_q         <= addr_d;
      own_q          <= own_d;
    end
  end

  assign render_data  = render_data_q;
  assign cpu_data_out = cpu_data_out_q;
  assign cpu_busy     = busy_q;
  assign chr_addr     = addr_q[12:0];

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Scoreboard bench for ppu_vram_ctrl: directed CPU/renderer accesses with
// queued expectations checked by an independent negedge monitor.
module tb_ppu_vram_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] render_addr;
  logic        render_active;
  logic [7:0]  render_data;
  logic [2:0]  cpu_reg_sel;
  logic        cpu_wr, cpu_rd;
  logic [7:0]  cpu_data_in, cpu_data_out;
  logic        cpu_busy;
  logic        inc32, mirror_vertical;
  logic [12:0] chr_addr;
  logic [7:0]  chr_data;

  ppu_vram_ctrl dut (
    .clk(clk), .reset(reset), .render_addr(render_addr), .render_active(render_active),
    .render_data(render_data), .cpu_reg_sel(cpu_reg_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_busy(cpu_busy),
    .inc32(inc32), .mirror_vertical(mirror_vertical), .chr_addr(chr_addr), .chr_data(chr_data)
  );

  always #5 clk = ~clk;

  // External CHR ROM stand-in with a recognisable pattern
  assign chr_data = chr_addr[7:0] ^ 8'hC3;

  typedef struct {
    int          due;
    logic [7:0]  exp;
    logic [15:0] addr;
  } rchk_t;

  logic [7:0] cq[$];
  rchk_t      rq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc_cnt = 0;
  logic [7:0] last_out = 8'h00;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: CPU result when busy drops, render result on its due cycle
  initial begin
    logic  busy_prev;
    logic [7:0] e;
    rchk_t r;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev && !cpu_busy) begin
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_unexpected: got 0x%0h with no pending access", cpu_data_out);
        end else begin
          e = cq.pop_front();
          chk("cpu_data_out", {8'h00, cpu_data_out}, {8'h00, e});
        end
      end
      if (rq.size() > 0 && rq[0].due == cyc_cnt) begin
        r = rq.pop_front();
        chk($sformatf("render_%0h", r.addr), {8'h00, render_data}, {8'h00, r.exp});
      end
      busy_prev = cpu_busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8 && cpu_busy; i++) step();
    if (cpu_busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1, expected 0");
    end
  endtask

  task automatic ppuaddr(input logic [7:0] d);
    cpu_reg_sel = 3'd6; cpu_data_in = d; cpu_wr = 1'b1;
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic set_v(input logic [15:0] a);
    ppuaddr(a[15:8]);
    ppuaddr(a[7:0]);
  endtask

  task automatic ppudata_wr(input logic [7:0] d);
    cq.push_back(last_out);
    cpu_reg_sel = 3'd7; cpu_data_in = d; cpu_wr = 1'b1;
    step();
    cpu_wr = 1'b0;
    wait_idle();
  endtask

  task automatic ppudata_rd(input logic [7:0] exp);
    cq.push_back(exp);
    last_out = exp;
    cpu_reg_sel = 3'd7; cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
    wait_idle();
  endtask

  task automatic status_rd();
    cpu_reg_sel = 3'd2; cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
  endtask

  task automatic render_chk(input logic [15:0] a, input logic [7:0] exp);
    render_addr = a;
    rq.push_back('{cyc_cnt + 2, exp, a});
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; render_addr = 16'h0000; render_active = 1'b0;
    cpu_reg_sel = 3'd0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_data_in = 8'h00;
    inc32 = 1'b0; mirror_vertical = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_render_data", {8'h00, render_data}, 16'h0000);
    chk("rst_cpu_data_out", {8'h00, cpu_data_out}, 16'h0000);
    chk("rst_busy", {15'h0, cpu_busy}, 16'h0000);
    chk("rst_chr_addr", {3'b000, chr_addr}, 16'h0000);
    chk("rst_v", {1'b0, dut.v_q}, 16'h0000);

    // Basic write, vertical mirror readback through the render port
    set_v(16'h2108);
    ppudata_wr(8'hAB);
    chk("v_after_wr", {1'b0, dut.v_q}, 16'h2109);
    render_chk(16'h2908, 8'hAB);

    // Increment by 32
    set_v(16'h2000);
    inc32 = 1'b1;
    ppudata_wr(8'h11);
    ppudata_wr(8'h22);
    inc32 = 1'b0;
    chk("v_inc32", {1'b0, dut.v_q}, 16'h2040);
    render_chk(16'h2000, 8'h11);
    render_chk(16'h2020, 8'h22);

    // Palette mirror and unbuffered palette read; buffer gets 0x2F00
    set_v(16'h2F00);
    ppudata_wr(8'h5A);
    set_v(16'h3F10);
    ppudata_wr(8'h0F);
    set_v(16'h3F00);
    ppudata_rd(8'h0F);
    render_chk(16'h3F10, 8'h0F);
    set_v(16'h3F14);
    ppudata_wr(8'h3C);
    render_chk(16'h3F04, 8'h3C);

    // Buffered nametable reads
    set_v(16'h2400);
    ppudata_wr(8'h55);
    ppudata_wr(8'h00);
    set_v(16'h2401);
    ppudata_rd(8'h5A);
    set_v(16'h2400);
    ppudata_rd(8'h00);
    set_v(16'h2400);
    ppudata_rd(8'h55);

    // Wrap at 0x3FFF, CHR write discarded, CHR reads through the buffer
    set_v(16'h3FFF);
    ppudata_wr(8'h01);
    chk("v_wrap", {1'b0, dut.v_q}, 16'h0000);
    ppudata_wr(8'h02);
    chk("v_after_chr_wr", {1'b0, dut.v_q}, 16'h0001);
    render_chk(16'h3FFF, 8'h01);
    render_chk(16'h0123, 8'hE0);
    set_v(16'h0123);
    ppudata_rd(8'h55);
    ppudata_rd(8'hE0);
    render_chk(16'hF108, 8'hAB);
    mirror_vertical = 1'b0;
    render_chk(16'h2508, 8'hAB);
    mirror_vertical = 1'b1;

    // PPUSTATUS read clears the address latch toggle
    ppuaddr(8'h3F);
    status_rd();
    ppuaddr(8'h00);
    ppuaddr(8'h05);
    chk("v_after_status", {1'b0, dut.v_q}, 16'h0005);

    // Strobe while busy is ignored
    set_v(16'h2200);
    cq.push_back(last_out);
    cpu_reg_sel = 3'd7; cpu_data_in = 8'h33; cpu_wr = 1'b1;
    step();
    cpu_reg_sel = 3'd6; cpu_data_in = 8'h3F;
    step();
    cpu_wr = 1'b0;
    wait_idle();
    chk("v_busy_ignore", {1'b0, dut.v_q}, 16'h2201);
    chk("w_busy_ignore", {15'h0, dut.w_q}, 16'h0000);
    render_chk(16'h2200, 8'h33);

    // Simultaneous write and read: write wins
    set_v(16'h2210);
    cq.push_back(last_out);
    cpu_reg_sel = 3'd7; cpu_data_in = 8'h44; cpu_wr = 1'b1; cpu_rd = 1'b1;
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    wait_idle();
    render_chk(16'h2210, 8'h44);

    // Renderer owns VRAM: no write, v still advances
    set_v(16'h2210);
    render_active = 1'b1;
    ppudata_wr(8'h99);
    render_active = 1'b0;
    chk("v_render_active", {1'b0, dut.v_q}, 16'h2211);
    render_chk(16'h2210, 8'h44);

    // Reset during WR aborts the write
    set_v(16'h2210);
    cpu_reg_sel = 3'd7; cpu_data_in = 8'h77; cpu_wr = 1'b1;
    step();
    cpu_wr = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {15'h0, cpu_busy}, 16'h0000);
    chk("abort_v", {1'b0, dut.v_q}, 16'h0000);
    chk("abort_cpu_data_out", {8'h00, cpu_data_out}, 16'h0000);
    render_chk(16'h2210, 8'h44);

    repeat (4) step();
    chk("scoreboard_drain", 16'(cq.size() + rq.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
